mm_ptr_fifo: RTL

//   Pointer-based FIFO between the memory-mapped coprocessor front-end and a

---
 rtl/mm_ptr_fifo_if.sv | 26 ++
 rtl/mm_ptr_fifo.sv | 82 ++++++++
 2 files changed

// File: rtl/mm_ptr_fifo_if.sv
// Bus-side write port and actor-side read port of the pointer FIFO.
// The slave modport is the FIFO itself; the master modport is its environment.
interface mm_ptr_fifo_if #(
  parameter int c_width    = 4,
  parameter int data_width = 32
);
  logic                  clear;
  logic                  wr_en;
  logic [data_width-1:0] wr_data;
  logic                  full;
  logic                  overflow;
  logic [data_width-1:0] out_data;
  logic                  out_send;
  logic                  out_ack;
  logic [c_width:0]      out_count;

  modport slave (
    input  clear, wr_en, wr_data, out_ack,
    output full, overflow, out_data, out_send, out_count
  );

  modport master (
    output clear, wr_en, wr_data, out_ack,
    input  full, overflow, out_data, out_send, out_count
  );
endinterface

// File: rtl/mm_ptr_fifo.sv
// Show-ahead pointer FIFO between the coprocessor loader and a dataflow actor.
// Occupancy is tracked by an explicit count so full and empty never alias.
module mm_ptr_fifo #(
  parameter int c_width    = 4,
  parameter int data_width = 32
) (
  input  logic         c_clk,
  input  logic         c_reset,
  mm_ptr_fifo_if.slave bus
);
  localparam int depth = 1 << c_width;
  localparam logic [c_width:0] count_full = {1'b1, {c_width{1'b0}}};

  logic [c_width-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_width-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_width:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  send_q, send_d;
  logic                  overflow_q, overflow_d;
  logic [data_width-1:0] mem_q [depth];

  logic wr_acc;
  logic rd_acc;

  // Both accepts look at registered flags, so a pop never frees a slot for a
  // same-cycle write and a write never feeds a same-cycle pop.
  assign wr_acc = bus.wr_en & ~full_q;
  assign rd_acc = bus.out_ack & send_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (bus.wr_en & full_q);
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
    full_d = (count_d == count_full);
    send_d = (count_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge c_clk or posedge c_reset) begin
    if (c_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      send_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      send_q     <= send_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; out_send gates validity, and unreset RAM maps to plain memory.
  always_ff @(posedge c_clk) begin
    if (wr_acc && !bus.clear) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_send  = send_q;
  assign bus.full      = full_q;
  assign bus.overflow  = overflow_q;
  assign bus.out_count = count_q;
endmodule
